// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready=1.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ERR      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;

    state_t cur, nxt;
    logic   mem_ok;
    logic [3:0] alu_r, alu_i;
    logic   branch_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    assign state     = cur;
    assign illegal   = (cur == S_ERR);
    assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

    // Register-register and immediate ALU decode; only R-type uses funct7b5 to pick sub.
    always_comb begin
        alu_r = ALU_ADD;
        alu_i = ALU_ADD;
        case (funct3)
            3'b000: begin
                alu_r = funct7b5 ? ALU_SUB : ALU_ADD;
                alu_i = ALU_ADD;
            end
            3'b001: begin alu_r = ALU_SLL; alu_i = ALU_SLL; end
            3'b010: begin alu_r = ALU_SLT; alu_i = ALU_SLT; end
            3'b011: begin alu_r = ALU_SLT; alu_i = ALU_SLT; end
            3'b100: begin alu_r = ALU_XOR; alu_i = ALU_XOR; end
            3'b101: begin
                alu_r = funct7b5 ? ALU_SRA : ALU_SRL;
                alu_i = funct7b5 ? ALU_SRA : ALU_SRL;
            end
            3'b110: begin alu_r = ALU_OR;  alu_i = ALU_OR;  end
            default: begin alu_r = ALU_AND; alu_i = ALU_AND; end
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_ITYPE:  imm_src = (funct3 == 3'b001 || funct3 == 3'b101) ? 2'b11 : 2'b00;
            default:   imm_src = 2'b00;
        endcase
    end

    always_comb begin
        nxt         = cur;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        instr_done  = 1'b0;
        case (cur)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ok;
                pc_write   = mem_ok;
                if (mem_ok) nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    default:           nxt = S_ERR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ok) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ok;
                if (mem_ok) nxt = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_r;
                nxt         = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_i;
                nxt         = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                // Unsupported branch conditions must not redirect the PC on their way to ERR.
                if (branch_ok) begin
                    pc_write   = zero ^ funct3[0];
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end else begin
                    nxt = S_ERR;
                end
            end
            S_ERR:   nxt = S_ERR;
            default: nxt = S_ERR;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream checked cycle-by-cycle against a reference model.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control;
    logic       instr_done, illegal;
    logic [3:0] state;

    localparam int W = 23;
    logic [W-1:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;

    // Mnemonic -> ALU code by funct3: add sll slt slt xor srl or and
    logic [3:0] alu_tab [8] = '{4'd0, 4'd6, 4'd5, 4'd5, 4'd4, 4'd7, 4'd3, 4'd2};

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] act_vec();
        return {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal};
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o, logic [2:0] f3);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [W-1:0] exp_out(int s, logic [6:0] o, logic [2:0] f3,
                                             logic f7, logic z, logic rdy);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, done = 0, ill = 0;
        logic [1:0] rs = 0, a = 0, b = 0;
        logic [3:0] alu = 0;
        logic [3:0] s4 = s[3:0];
        case (s)
            0:  begin b = 2; rs = 2; irw = rdy; pcw = rdy; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; done = 1; end
            5:  begin adr = 1; mw = 1; done = rdy; end
            6:  begin a = 2; alu = (f3 == 0 && f7) ? 4'd1 : (f3 == 5 && f7) ? 4'd8 : alu_tab[f3]; end
            7:  begin rw = 1; done = 1; end
            8:  begin a = 2; b = 1; alu = (f3 == 5 && f7) ? 4'd8 : alu_tab[f3]; end
            9:  begin a = 2; alu = 4'd1; pcw = z ^ f3[0]; done = 1; end
            default: ill = 1;
        endcase
        return {s4, pcw, adr, mw, irw, rw, rs, a, b, imm_of(o, f3), alu, done, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every cycle that has an expectation queued is compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (e[1]) n_done++;
            check($sformatf("cycle st=%0d", e[W-1 -: 4]), 32'(act_vec()), 32'(e));
        end
    end

    // Drives one instruction from FETCH to completion (or 10 cycles of ERR).
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int forced_wait);
        int seq[$];
        int waits;
        logic rdy;
        seq = {0, 1};
        case (o)
            7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            7'b0100011: begin seq.push_back(2); seq.push_back(5); end
            7'b0110011: begin seq.push_back(6); seq.push_back(7); end
            7'b0010011: begin seq.push_back(8); seq.push_back(7); end
            7'b1100011: seq.push_back(9);
            default: for (int i = 0; i < 10; i++) seq.push_back(15);
        endcase
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        foreach (seq[k]) begin
            waits = 0;
`ifdef MEM_WAIT_EN
            if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5)
                waits = (forced_wait >= 0 && seq[k] == 5) ? forced_wait : $urandom_range(0, 2);
`endif
            for (int w = 0; w <= waits; w++) begin
`ifdef MEM_WAIT_EN
                mem_ready = (w == waits);
                rdy = mem_ready;
`else
                mem_ready = 1'($urandom_range(0, 1));
                rdy = 1'b1;
`endif
                exp_q.push_back(exp_out(seq[k], o, f3, f7, z, rdy));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
        logic [6:0] o;
        logic [2:0] f3;
        int done_before;
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(act_vec()), 32'(exp_out(0, op, funct3, 1'b0, 1'b0, 1'b1)));
        rst_n = 1'b1;

        // Abort a lw in MEMREAD with an asynchronous reset.
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_state", 32'(state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_reg_write", 32'(reg_write), 32'd0);
        check("async_reset_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release_state", 32'(state), 32'd1);
        restart();

        done_before = n_done;
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 4)];
            f3 = 3'($urandom_range(0, 7));
            if (o == 7'b1100011) f3 = {2'b00, f3[0]};
            else if (f3 == 3'd3) f3 = 3'd2;
            run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        // Directed cases: lw, slli, srai, beq/bne with zero=1, sw with a long memory stall.
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, -1);
        run_instr(7'b0010011, 3'd1, 1'b0, 1'b0, -1);
        run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, -1);
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, -1);
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, -1);
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, -1);
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, -1);
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 3);
        check("instr_done_count", 32'(n_done - done_before), 32'd48);

        done_before = n_done;
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, -1);
        check("no_done_in_err", 32'(n_done - done_before), 32'd0);
        check("illegal_held", 32'(illegal), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        restart();
        check("illegal_cleared", 32'(illegal), 32'd0);
        check("fetch_after_err_reset", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over multiple cycles of a shared ALU and unified memory port. Drives the datapath multiplexers, write enables, ALU operation and the 2-bit immediate-format select consumed by the immediate extender. Supports lw, sw, R-type ALU, I-type ALU (including shift-immediates) and beq/bne.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=ALU result register
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction/old-PC register enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALU out reg, 01=read data reg, 10=ALU result
- alu_src_a  out  2  00=PC, 01=old PC, 10=rs1 reg
- alu_src_b  out  2  00=rs2 reg, 01=immext, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=5-bit shamt (zero-extended)
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  sticky; unsupported opcode decoded
- state  out  4  current state, for debug

## Operation
- Moore FSM; 4-bit state register, all outputs combinational from state (plus op/funct fields/zero/mem_ready where stated).
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, BRANCH=9, ERR=15.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10, ir_write=pc_write=1 -> DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target); dispatch on op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, else -> ERR.
- MEMADR: alu_src_a=10, alu_src_b=01, add; lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adr_src=1 -> MEMWB. MEMWB: result_src=01, reg_write=1, instr_done -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1, instr_done -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALU op from funct3/funct7b5 (000 with funct7b5=1 -> sub) -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALU op from funct3; funct7b5 is ignored for addi; 101 with funct7b5=1 -> sra -> ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero^funct3[0]. funct3 other than 000/001 -> ERR. Otherwise instr_done -> FETCH.
- imm_src decoded from op in all states: 0000011 -> 00; 0100011 -> 01; 1100011 -> 10; 0010011 -> 11 if funct3 is 001 or 101, else 00; otherwise 00.
- ERR: all enables 0, illegal=1, state held until rst_n.
- Write enables are 0 in every state not listed for them.

## Timing
- Reset (rst_n=0, asynchronous): state=FETCH, illegal=0. Outputs take their FETCH values, with ir_write/pc_write gated by mem_ready when MEM_WAIT_EN is defined. Reset mid-instruction aborts it; no writes issue after rst_n falls.
- Cycles per instruction without waits: lw 5, sw 4, R 4, I 4, branch 3.
- instr_done asserts in exactly one cycle per instruction; never in ERR.

## Configuration
- MEM_WAIT_EN defined: FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
  - In FETCH, ir_write/pc_write assert only in the mem_ready cycle.
  - In MEMWRITE, mem_write stays high throughout the wait; instr_done asserts in the mem_ready cycle.
  - Each wait cycle adds one cycle of latency.
- MEM_WAIT_EN undefined: mem_ready is ignored and every memory access takes one cycle.

## Test plan
- Reset mid-MEMREAD: state returns to 0 asynchronously, reg_write=0; next edge after release moves to DECODE.
- lw (op=0000011): states 0,1,2,3,4 in sequence; imm_src=00; reg_write only in state 4; instr_done once.
- slli (op=0010011, funct3=001): imm_src=11, alu_control=0110. srai (funct3=101, funct7b5=1): alu_control=1000.
- beq, zero=1: pc_write=1 in BRANCH. bne, zero=1: pc_write=0. Both have imm_src=10 and take 3 cycles.
- op=1101111: ERR reached after DECODE, illegal=1 and held; no enables over 10 cycles.
- MEM_WAIT_EN, sw with mem_ready low for 3 cycles: mem_write stays high for 4 cycles; instr_done asserts only in the final cycle.
